reader: RTL and testbench

AXI4 read-only master that reads back the 512 KiB BRAM region a fill pass has just written and checks every beat against the expected fill content. Expected content is either the incrementing 16-bit counter pattern, replicated across the bus, or all zeros. It sits beside the fill writer on the same interconnect slave port and reports pass/fail, an error count and the first failing address to the host logic.

---
 rtl/reader.sv | 183 ++++++++++++++++++
 tb/tb_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reader.sv
// AXI4 read-only checker: reads back the 512 KiB BRAM region and compares each beat with the fill pattern.
// Optional READER_RLAST_CHECK_EN also flags beats whose RLAST disagrees with the beat position.
module reader #(
   parameter int unsigned DW              = 512,
   parameter int unsigned AW              = 19,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          zero_mode,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [15:0]   err_count,
   output logic [AW-1:0] first_err_addr,
   output logic [AW-1:0] M_AXI_ARADDR,
   output logic          M_AXI_ARVALID,
   output logic [7:0]    M_AXI_ARLEN,
   output logic [2:0]    M_AXI_ARSIZE,
   output logic [1:0]    M_AXI_ARBURST,
   output logic [2:0]    M_AXI_ARPROT,
   output logic [3:0]    M_AXI_ARID,
   output logic [3:0]    M_AXI_ARCACHE,
   output logic [3:0]    M_AXI_ARQOS,
   output logic          M_AXI_ARLOCK,
   input  logic          M_AXI_ARREADY,
   input  logic [DW-1:0] M_AXI_RDATA,
   input  logic [1:0]    M_AXI_RRESP,
   input  logic          M_AXI_RLAST,
   input  logic          M_AXI_RVALID,
   output logic          M_AXI_RREADY
);

   localparam int unsigned BYTES           = DW / 8;
   localparam int unsigned BURST_SIZE      = 4096;
   localparam int unsigned BEATS_PER_BURST = BURST_SIZE / BYTES;
   localparam int unsigned TOTAL_BURSTS    = 128;
   localparam int unsigned BEAT_W          = $clog2(BEATS_PER_BURST + 1);
   localparam int unsigned BURST_W         = $clog2(TOTAL_BURSTS + 1);
   localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1) + 1;

   typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;

   ar_state_t           ar_state;
   logic [AW-1:0]       araddr_q;
   logic                arvalid_q;
   logic [BURST_W-1:0]  ar_issued;
   logic [OUT_W-1:0]    outstanding;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic [15:0]         err_q;
   logic [AW-1:0]       first_q;
   logic                zero_q;
   logic [15:0]         exp_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [BURST_W-1:0]  r_burst_q;

   logic                ar_hs;
   logic                r_hs;
   logic                burst_end;
   logic                burst_done;
   logic                last_beat;
   logic                rlast_err;
   logic                beat_err;
   logic [DW-1:0]       exp_data;
   logic [AW-1:0]       beat_addr;
   logic [OUT_W-1:0]    out_next;
   logic                ar_room;

   assign ar_hs      = arvalid_q & M_AXI_ARREADY;
   assign r_hs       = busy_q & M_AXI_RVALID;
   assign burst_end  = (beat_q == BEAT_W'(BEATS_PER_BURST));
   assign burst_done = r_hs & burst_end;
   assign last_beat  = burst_done & (r_burst_q == BURST_W'(TOTAL_BURSTS - 1));
   assign exp_data   = zero_q ? '0 : {(DW/16){exp_q}};
   assign beat_addr  = AW'(r_burst_q) * AW'(BURST_SIZE) + AW'(beat_q - BEAT_W'(1)) * AW'(BYTES);
   assign out_next   = outstanding + OUT_W'(ar_hs) - OUT_W'(burst_done);
   assign ar_room    = (out_next < OUT_W'(MAX_OUTSTANDING));

`ifdef READER_RLAST_CHECK_EN
   assign rlast_err = (M_AXI_RLAST != burst_end);
`else
   logic unused_rlast;
   assign unused_rlast = M_AXI_RLAST;
   assign rlast_err    = 1'b0;
`endif

   assign beat_err = r_hs & ((M_AXI_RDATA != exp_data) | (M_AXI_RRESP != 2'b00) | rlast_err);

   // AR issue FSM, R-side beat checker and pass bookkeeping
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ar_state    <= AR_IDLE;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         ar_issued   <= '0;
         outstanding <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         first_q     <= '0;
         zero_q      <= 1'b0;
         exp_q       <= '0;
         beat_q      <= '0;
         r_burst_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (start && !busy_q) begin
            ar_state    <= AR_ISSUE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b1;
            ar_issued   <= '0;
            outstanding <= '0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
            zero_q      <= zero_mode;
            exp_q       <= 16'd1;
            beat_q      <= BEAT_W'(1);
            r_burst_q   <= '0;
         end else begin
            outstanding <= out_next;
            case (ar_state)
               AR_ISSUE: begin
                  // the cap gates only a fresh assertion; a pending request holds until accepted
                  if (ar_hs) begin
                     araddr_q  <= araddr_q + AW'(BURST_SIZE);
                     ar_issued <= ar_issued + BURST_W'(1);
                     if (ar_issued == BURST_W'(TOTAL_BURSTS - 1)) begin
                        ar_state  <= AR_IDLE;
                        arvalid_q <= 1'b0;
                     end else begin
                        arvalid_q <= ar_room;
                     end
                  end else if (!arvalid_q) begin
                     arvalid_q <= ar_room;
                  end
               end
               default: ;
            endcase

            if (r_hs) begin
               exp_q  <= exp_q + 16'd1;
               beat_q <= burst_end ? BEAT_W'(1) : beat_q + BEAT_W'(1);
               if (burst_end) r_burst_q <= r_burst_q + BURST_W'(1);
            end

            if (beat_err) begin
               if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
               if (err_q == 16'd0) first_q <= beat_addr;
            end

            if (last_beat) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               pass_q <= (err_q == 16'd0) && !beat_err;
            end
         end
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;
   assign M_AXI_ARADDR   = araddr_q;
   assign M_AXI_ARVALID  = arvalid_q;
   assign M_AXI_RREADY   = busy_q;
   assign M_AXI_ARLEN    = 8'(BEATS_PER_BURST - 1);
   assign M_AXI_ARSIZE   = 3'($clog2(BYTES));
   assign M_AXI_ARBURST  = 2'd1;
   assign M_AXI_ARPROT   = 3'd2;
   assign M_AXI_ARID     = 4'd0;
   assign M_AXI_ARCACHE  = 4'd0;
   assign M_AXI_ARQOS    = 4'd0;
   assign M_AXI_ARLOCK   = 1'b0;

endmodule

// File: tb/tb_reader.sv
// Bench for reader: randomized AXI slave model plus a per-beat reference of the expected checker results.
module tb_reader;

   localparam int unsigned DW     = 512;
   localparam int unsigned AW     = 19;
   localparam int unsigned MAXO   = 4;
   localparam int unsigned BYTES  = DW / 8;
   localparam int unsigned BPB    = 4096 / BYTES;
   localparam int unsigned NBURST = 128;
   localparam int unsigned NBEATS = NBURST * BPB;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic          zero_mode = 1'b0;
   logic          busy, done, pass;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [AW-1:0] ARADDR;
   logic          ARVALID;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE;
   logic [1:0]    ARBURST;
   logic [2:0]    ARPROT;
   logic [3:0]    ARID, ARCACHE, ARQOS;
   logic          ARLOCK;
   logic          ARREADY = 1'b0;
   logic [DW-1:0] RDATA = '0;
   logic [1:0]    RRESP = 2'b00;
   logic          RLAST = 1'b0;
   logic          RVALID = 1'b0;
   logic          RREADY;

   reader dut (
      .clk(clk), .resetn(resetn), .start(start), .zero_mode(zero_mode),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARLEN(ARLEN),
      .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARPROT(ARPROT),
      .M_AXI_ARID(ARID), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARQOS(ARQOS),
      .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA),
      .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID),
      .M_AXI_RREADY(RREADY)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // pass configuration, written by the main sequence only
   bit cfg_zero, cfg_ar_rand, cfg_r_rand;
   int cfg_stall, cfg_corrupt, cfg_rresp, cfg_rlast;

   // slave and reference-model state, written by the slave process only
   int     ar_q[$];
   int     ar_cnt, gbeat, inburst, ars_at_first_beat, scyc, stall_until;
   int     m_err;
   longint m_first;

   // AXI read slave serving bursts in order; scores each accepted beat against the fill rules
   initial begin
      logic          s_ar_hs, s_r_hs, s_start, s_stall;
      logic [AW-1:0] s_araddr, s_stall_addr;
      logic [DW-1:0] d, expd;
      logic [15:0]   v;
      int            ar_before, k;
      bit            e;
      s_stall = 1'b0;
      s_stall_addr = '0;
      scyc = 0;
      stall_until = 0;
      forever begin
         @(negedge clk);
         if (resetn && s_stall) begin
            check("ar_hold_valid", ARVALID, 1);
            check("ar_hold_addr", ARADDR, s_stall_addr);
         end
         s_stall      = resetn && ARVALID && !ARREADY;
         s_stall_addr = ARADDR;
         s_ar_hs      = ARVALID && ARREADY;
         s_r_hs       = RVALID && RREADY;
         s_araddr     = ARADDR;
         s_start      = resetn && start && !busy;
         @(posedge clk);
         #1;
         scyc++;
         if (!resetn || s_start) begin
            ar_q.delete();
            ar_cnt = 0; gbeat = 0; inburst = 0; ars_at_first_beat = -1;
            m_err = 0; m_first = -1;
            stall_until = scyc + cfg_stall;
            s_stall = 1'b0;
            ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
            if (!resetn) continue;
         end
         ar_before = ar_cnt;
         if (s_ar_hs) begin
            check("ar_outstanding_cap", ar_q.size() < MAXO, 1);
            check("araddr", s_araddr, 64'(ar_cnt * 4096));
            ar_q.push_back(ar_cnt);
            ar_cnt++;
         end
         if (s_r_hs) begin
            if (gbeat == 0) ars_at_first_beat = ar_before;
            gbeat++;
            inburst++;
            v = 16'(gbeat);
            expd = cfg_zero ? '0 : {(DW/16){v}};
            e = (RDATA !== expd) || (RRESP != 2'b00);
`ifdef READER_RLAST_CHECK_EN
            e = e || (RLAST != (inburst == BPB));
`endif
            if (e) begin
               m_err++;
               if (m_first < 0) m_first = longint'(gbeat - 1) * BYTES;
            end
            if (inburst == BPB) begin
               void'(ar_q.pop_front());
               inburst = 0;
            end
         end
         ARREADY = cfg_ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (ar_q.size() > 0 && scyc >= stall_until && (!cfg_r_rand || $urandom_range(0, 3) != 0)) begin
            k = gbeat + 1;
            v = 16'(k);
            d = {(DW/16){v}};
            if (k == cfg_corrupt) d[$urandom_range(0, DW - 1)] ^= 1'b1;
            RVALID = 1'b1;
            RDATA  = d;
            RRESP  = (k == cfg_rresp) ? 2'b10 : 2'b00;
            RLAST  = ((inburst + 1) == BPB) ^ (k == cfg_rlast);
         end else begin
            RVALID = 1'b0;
            RDATA  = '0;
            RRESP  = 2'b00;
            RLAST  = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arvalid"}, ARVALID, 0);
      check({tag, "_araddr"}, ARADDR, 0);
      check({tag, "_rready"}, RREADY, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_first_err"}, first_err_addr, 0);
      check({tag, "_arlen"}, ARLEN, 63);
      check({tag, "_arsize"}, ARSIZE, 6);
      check({tag, "_arburst"}, ARBURST, 1);
      check({tag, "_arprot"}, ARPROT, 2);
      check({tag, "_ar_zero_fields"}, {ARID, ARCACHE, ARQOS, ARLOCK}, 0);
   endtask

   task automatic run_pass(input string name, input bit zero, input bit arr, input bit rr,
                           input int stall, input int cb, input int rb, input int lb,
                           input int abort_at, input bit midstart);
      bit seen;
      cfg_zero = zero; cfg_ar_rand = arr; cfg_r_rand = rr; cfg_stall = stall;
      cfg_corrupt = cb; cfg_rresp = rb; cfg_rlast = lb;
      @(posedge clk);
      #1;
      zero_mode = zero;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      zero_mode = 1'($urandom);
      @(negedge clk);
      check({name, "_busy_start"}, busy, 1);
      check({name, "_arvalid_start"}, ARVALID, 1);
      check({name, "_rready_start"}, RREADY, 1);
      check({name, "_cleared"}, {pass, err_count, 13'(first_err_addr)}, 0);
      if (stall > 0) begin
         repeat (40) @(negedge clk);
         check({name, "_ars_in_stall"}, ar_cnt, MAXO);
         check({name, "_arvalid_capped"}, ARVALID, 0);
      end
      seen = 1'b0;
      for (int cyc = 0; cyc < 40000; cyc++) begin
         @(negedge clk);
         start = midstart && gbeat >= 100 && gbeat < 110;
         zero_mode = ~zero;
         if (abort_at > 0 && gbeat >= abort_at) begin
            start = 1'b0;
            @(posedge clk);
            #2;
            resetn = 1'b0;
            #1;
            check_reset_outputs({name, "_abort"});
            repeat (3) @(negedge clk);
            check({name, "_in_reset_busy"}, busy, 0);
            @(posedge clk);
            #2;
            resetn = 1'b1;
            return;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) begin
         check({name, "_done_timeout"}, 0, 1);
         return;
      end
      check({name, "_busy_end"}, busy, 0);
      check({name, "_rready_end"}, RREADY, 0);
      check({name, "_ar_count"}, ar_cnt, NBURST);
      check({name, "_beats"}, gbeat, NBEATS);
      check({name, "_pass"}, pass, m_err == 0);
      check({name, "_err_count"}, err_count, (m_err > 65535) ? 65535 : m_err);
      check({name, "_first_err"}, first_err_addr, (m_first < 0) ? 0 : m_first);
      if (stall > 0) check({name, "_ars_before_beat"}, ars_at_first_beat, MAXO);
      @(negedge clk);
      check({name, "_done_pulse"}, done, 0);
      check({name, "_pass_held"}, pass, m_err == 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #2;
      resetn = 1'b1;
      run_pass("clean",   0, 0, 0,  0,  0,   0,   0,    0, 1);
      run_pass("corrupt", 0, 1, 1,  0, 70,   0,   0,    0, 0);
      check("corrupt_first_addr_const", first_err_addr, 'h1140);
      run_pass("zero",    1, 0, 0,  0,  0,   0,   0,    0, 0);
      check("zero_err_const", err_count, NBEATS);
      run_pass("rstall",  0, 0, 0, 50,  0, 200, 266,    0, 0);
      run_pass("abort",   0, 1, 1,  0,  0,   0,   0, 3000, 0);
      run_pass("fresh",   0, 1, 1,  0,  0,   0,   0,    0, 0);
      check("fresh_pass_const", pass, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
